vga_timing_gen: RTL and testbench

- Pixel-timing generator directly upstream of the sprite/palette drawing stages.
- Produces the DrawX/DrawY raster coordinates, the active-video qualifier `blank` (1 = visible pixel, draw), and active-low hsync/vsync.
- Adds frame/line strobes and a frame counter for sprite animation.
- Runs entirely in the vga_clk domain; its outputs feed the draw stage, which registers colour on the same posedge.

---
 rtl/vga_timing_gen.sv | 97 +++++++++
 tb/tb_vga_timing_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: DrawX/DrawY counters plus registered
// blank, sync, line/frame strobes and a free-running frame counter.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       blank_q, blank_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic [7:0] fc_q, fc_d;
    logic       h_wrap;

    // Next raster position and the decodes that belong to it, so every
    // registered qualifier lines up with the coordinate it is stored with.
    always_comb begin
        h_wrap  = (x_q == H_LAST);
        x_d     = h_wrap ? 10'd0 : x_q + 10'd1;
        y_d     = y_q;
        if (h_wrap) begin
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end
        blank_d = (x_d < H_VIS) && (y_d < V_VIS);
        hs_d    = !((x_d >= HS_START) && (x_d < HS_END));
        vs_d    = !((y_d >= VS_START) && (y_d < VS_END));
        ls_d    = (x_d == 10'd0);
        fs_d    = ls_d && (y_d == 10'd0);
        fc_d    = fs_d ? fc_q + 8'd1 : fc_q;
    end

    // State registers; reset parks on the last pixel so the first edge
    // after release lands on (0,0) and starts a fresh frame.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= H_LAST;
            y_q     <= V_LAST;
            blank_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= 8'd0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            blank_q <= blank_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line timing, a
// shrunken instance for whole-frame and frame-counter-wrap behaviour.
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hsy, hb, vv, vf, vsy, vb;
    } timing_t;

    typedef struct {
        int x, y;
        bit bl, h, v, ls, fs;
        int fc;
    } exp_t;

    typedef struct {
        longint t;
        exp_t   e;
    } vec_t;

    localparam timing_t PA = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam timing_t PB = '{8, 1, 2, 1, 4, 1, 2, 1};

    logic clk;
    logic ra_n, rb_n;
    logic [9:0] ax, ay, bx, by;
    logic abl, ahs, avs, als, afs;
    logic bbl, bhs, bvs, bls, bfs;
    logic [7:0] afc, bfc;
    longint ta, tb_cnt;
    int errors, checks, shown;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .vga_clk(clk), .reset_n(ra_n),
        .DrawX(ax), .DrawY(ay), .blank(abl), .hs(ahs), .vs(avs),
        .line_start(als), .frame_start(afs), .frame_count(afc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_b (
        .vga_clk(clk), .reset_n(rb_n),
        .DrawX(bx), .DrawY(by), .blank(bbl), .hs(bhs), .vs(bvs),
        .line_start(bls), .frame_start(bfs), .frame_count(bfc)
    );

    // Reference time: clock edges seen since each reset was released.
    always @(posedge clk or negedge ra_n)
        if (!ra_n) ta <= 0; else ta <= ta + 1;
    always @(posedge clk or negedge rb_n)
        if (!rb_n) tb_cnt <= 0; else tb_cnt <= tb_cnt + 1;

    // Raster position derived arithmetically from elapsed clocks.
    function automatic exp_t model(timing_t p, longint t);
        exp_t e;
        longint ht, vt, c;
        ht = p.hv + p.hf + p.hsy + p.hb;
        vt = p.vv + p.vf + p.vsy + p.vb;
        if (t == 0) begin
            e = '{int'(ht - 1), int'(vt - 1), 0, 1, 1, 0, 0, 0};
        end else begin
            c    = t - 1;
            e.x  = int'(c % ht);
            e.y  = int'((c / ht) % vt);
            e.bl = (e.x < p.hv) && (e.y < p.vv);
            e.h  = !(e.x >= p.hv + p.hf && e.x < p.hv + p.hf + p.hsy);
            e.v  = !(e.y >= p.vv + p.vf && e.y < p.vv + p.vf + p.vsy);
            e.ls = (e.x == 0);
            e.fs = (e.x == 0) && (e.y == 0);
            e.fc = int'((c / (ht * vt) + 1) % 256);
        end
        return e;
    endfunction

    task automatic cmp(string tag, exp_t e, logic [9:0] x, logic [9:0] y,
                       logic bl, logic h, logic v, logic ls, logic fs,
                       logic [7:0] fc);
        logic [32:0] act, req;
        act = {x, y, bl, h, v, ls, fs, fc};
        req = {10'(e.x), 10'(e.y), e.bl, e.h, e.v, e.ls, e.fs, 8'(e.fc)};
        checks++;
        if (act !== req) begin
            errors++;
            if (shown < 20) begin
                shown++;
                $display("FAIL %s got x=%0d y=%0d bl=%b hs=%b vs=%b ls=%b fs=%b fc=%0d required x=%0d y=%0d bl=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                         tag, x, y, bl, h, v, ls, fs, fc,
                         e.x, e.y, e.bl, e.h, e.v, e.ls, e.fs, e.fc);
            end
        end
    endtask

    task automatic chk(string tag, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            if (shown < 20) begin
                shown++;
                $display("FAIL %s got %0d required %0d", tag, act, req);
            end
        end
    endtask

    task automatic check_a(string tag);
        cmp(tag, model(PA, ta), ax, ay, abl, ahs, avs, als, afs, afc);
    endtask

    task automatic check_b(string tag);
        cmp(tag, model(PB, tb_cnt), bx, by, bbl, bhs, bvs, bls, bfs, bfc);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    vec_t vecs[11];

    initial begin
        int hcnt, hfirst, hlast, hbad;
        longint last_fs, vstart;
        int vrun, vsx, vsy, wraps, nfs;
        logic prev_v;
        logic [7:0] prev_fc;

        errors = 0; checks = 0; shown = 0;

        vecs[0]  = '{0,    '{799, 524, 0, 1, 1, 0, 0, 0}};
        vecs[1]  = '{1,    '{0,   0,   1, 1, 1, 1, 1, 1}};
        vecs[2]  = '{640,  '{639, 0,   1, 1, 1, 0, 0, 1}};
        vecs[3]  = '{641,  '{640, 0,   0, 1, 1, 0, 0, 1}};
        vecs[4]  = '{657,  '{656, 0,   0, 0, 1, 0, 0, 1}};
        vecs[5]  = '{752,  '{751, 0,   0, 0, 1, 0, 0, 1}};
        vecs[6]  = '{753,  '{752, 0,   0, 1, 1, 0, 0, 1}};
        vecs[7]  = '{800,  '{799, 0,   0, 1, 1, 0, 0, 1}};
        vecs[8]  = '{801,  '{0,   1,   1, 1, 1, 1, 0, 1}};
        vecs[9]  = '{1601, '{0,   2,   1, 1, 1, 1, 0, 1}};
        vecs[10] = '{8001, '{0,   10,  1, 1, 1, 1, 0, 1}};

        ra_n = 1'b0;
        rb_n = 1'b0;
        repeat (3) tick();
        cmp("reset_a", vecs[0].e, ax, ay, abl, ahs, avs, als, afs, afc);
        check_b("reset_b");

        ra_n = 1'b1;
        for (int i = 1; i < 11; i++) begin
            while (ta < vecs[i].t) tick();
            cmp($sformatf("vec%0d", i), vecs[i].e,
                ax, ay, abl, ahs, avs, als, afs, afc);
        end

        // hsync window across line 10
        hcnt = 0; hfirst = -1; hlast = -1; hbad = 0;
        for (int i = 0; i < 800; i++) begin
            if (ahs == 1'b0) begin
                hcnt++;
                if (hfirst < 0) hfirst = int'(ax);
                hlast = int'(ax);
                if (abl !== 1'b0) hbad++;
            end
            if (ay != 10'd10) hbad++;
            if (i < 799) tick();
        end
        chk("hs_count", hcnt, 96);
        chk("hs_first", hfirst, 656);
        chk("hs_last", hlast, 751);
        chk("hs_blank", hbad, 0);

        // mid-frame reset of the full-size instance at (300,11)
        while (ta < 11 * 800 + 301) tick();
        check_a("pre_reset_a");
        #2 ra_n = 1'b0;
        #1;
        cmp("async_reset_a", vecs[0].e, ax, ay, abl, ahs, avs, als, afs, afc);
        tick();
        ra_n = 1'b1;
        tick();
        cmp("restart_a", vecs[1].e, ax, ay, abl, ahs, avs, als, afs, afc);

        // whole frames on the small instance, through the counter wrap
        rb_n = 1'b1;
        last_fs = -1; vrun = 0; vstart = -1; vsx = 0; vsy = 0;
        wraps = 0; nfs = 0; prev_v = 1'b1; prev_fc = 8'd0;
        for (int i = 0; i < 258 * 96; i++) begin
            tick();
            check_b("frame_b");
            if (bfs) begin
                nfs++;
                if (last_fs >= 0) chk("fs_period", tb_cnt - last_fs, 96);
                last_fs = tb_cnt;
                if (prev_fc == 8'd255) begin
                    wraps++;
                    chk("fc_wrap", bfc, 0);
                end
            end
            if (!bvs && prev_v) begin
                vstart = tb_cnt; vsx = int'(bx); vsy = int'(by);
            end
            if (bvs && !prev_v && vstart >= 0) begin
                vrun++;
                chk("vs_len", tb_cnt - vstart, 24);
                chk("vs_start_x", vsx, 0);
                chk("vs_start_y", vsy, 5);
            end
            prev_v  = bvs;
            prev_fc = bfc;
        end
        chk("fc_wraps", wraps, 1);
        chk("fs_total", nfs, 258);
        chk("vs_pulses", vrun, 258);

        // mid-frame reset of the small instance at (5,3)
        rb_n = 1'b0;
        tick();
        rb_n = 1'b1;
        while (tb_cnt < 3 * 12 + 5 + 1) tick();
        chk("b_at_x", bx, 5);
        chk("b_at_y", by, 3);
        #2 rb_n = 1'b0;
        #1 check_b("async_reset_b");
        chk("async_b_x", bx, 11);
        chk("async_b_fc", bfc, 0);
        tick();
        rb_n = 1'b1;
        tick();
        check_b("restart_b");
        chk("restart_b_fs", bfs, 1);

        // random runs with random asynchronous resets on both instances
        for (int i = 0; i < 30; i++) begin
            int n;
            n = $urandom_range(150, 1);
            repeat (n) tick();
            check_a("rand_a");
            check_b("rand_b");
            if ($urandom_range(1, 0) == 1) begin
                #($urandom_range(4, 1));
                if ($urandom_range(1, 0) == 1) ra_n = 1'b0;
                else rb_n = 1'b0;
                #0.5;
                check_a("rand_rst_a");
                check_b("rand_rst_b");
                repeat ($urandom_range(3, 1)) tick();
                check_a("rand_held_a");
                check_b("rand_held_b");
                ra_n = 1'b1;
                rb_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
